sad_min_reader: RTL and testbench
=================================

Name: sad_min_reader

Overview:
Reader side of the SAD result RAM. The SAD datapath writes one SAD value per candidate block into the single-port result RAM. On a start pulse, this block scans every RAM entry in address order and reports the minimum SAD and its address, i.e. the best-match candidate. It drives the RAM address/read port only, with write-enable held low, and hands the result to downstream motion-estimation control through a done pulse.

Parameters:
DATA_WIDTH, 10, width of one stored SAD value.
ADDR_WIDTH, 2, RAM address width.
NUM_ENTRIES, 4, number of entries scanned, addresses 0..NUM_ENTRIES-1; must be ≤ 2**ADDR_WIDTH and ≥ 1.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  single-cycle request to begin a scan; sampled only in IDLE.
ram_addr  output  ADDR_WIDTH  read address to the result RAM.
ram_we  output  1  RAM write enable; constant 0.
ram_q  input  DATA_WIDTH  RAM read data. Synchronous read: valid the cycle after ram_addr is registered by the RAM.
busy  output  1  high while a scan is in progress.
done  output  1  one-cycle pulse when the result is valid.
min_sad  output  DATA_WIDTH  minimum SAD of the last completed scan.
min_addr  output  ADDR_WIDTH  address of that minimum.

Behaviour:
- Reset (async, any state): FSM→IDLE; ram_addr=0, busy=0, done=0, min_sad=0, min_addr=0; internal read pipeline valid flag cleared; running min/index cleared.
- FSM states:
  - IDLE: on start=1, go to SCAN; set ram_addr=0, busy=1; load running_min=all ones and running_idx=0; clear the "first compare" flag.
  - SCAN: ram_addr increments by 1 per cycle up to NUM_ENTRIES-1, then the FSM goes to DRAIN. Issue counter width is ADDR_WIDTH+1 so NUM_ENTRIES=2**ADDR_WIDTH does not wrap early. ram_addr holds its last value in DRAIN and IDLE.
  - DRAIN: waits for the last read data to be compared. It then goes to IDLE, copies running_min/running_idx to min_sad/min_addr, pulses done, and drops busy, all on the same edge.
- Read pipeline: a delayed-address/valid pipeline is 2 stages deep, matching the RAM address register plus the compare register. Data for address k is compared at the second edge after ram_addr=k was driven.
- Compare rule:
  - Update when ram_q < running_min (strict, unsigned), or on the first compare of the scan.
  - Ties keep the lower address.
  - A value of all ones must still be captured, via the first-compare rule.
- Latency: with the start edge as E0, done is high in the cycle after edge E(NUM_ENTRIES+1), i.e. after 5 edges for NUM_ENTRIES=4. busy is high from E0 to E(NUM_ENTRIES+1).
- min_sad/min_addr change only on the done edge and hold until the next done or reset.
- start while busy is ignored, with no restart and no queueing. start in the cycle done is high is accepted, because the FSM is in IDLE; the new scan then begins.
- Reset mid-scan aborts with no done pulse, and outputs return to reset values.
- ram_we is always 0; this block never writes.

Test Plan:
- RAM = [37,12,50,12], start pulse → busy high 5 cycles; done pulses once on the 5th edge after start; min_sad=12, min_addr=1 (tie keeps the lower address).
- RAM = [1023,1023,1023,1023] → min_sad=1023, min_addr=0 (first-compare capture of all ones).
- RAM = [900,800,700,3] → min_sad=3, min_addr=3; ram_addr sequence 0,1,2,3 on consecutive cycles, then holds at 3.
- RAM = [5,9,9,9]; start, then start pulsed again 2 cycles later → exactly one done; min_sad=5, min_addr=0; the second start is ignored.
- Assert rst 3 cycles into a scan → busy=0, done=0, min_sad=0, min_addr=0 immediately (asynchronously); no done pulse follows. A fresh start on RAM = [40,30,20,10] then gives min_sad=10, min_addr=3.
- start held high through the done cycle → a second scan begins immediately (busy back to 1 the next cycle); second done gives the same results; ram_we stays 0 throughout.

Source files
------------

// File: rtl/sad_min_reader.sv
// Scans the SAD result RAM after a start pulse and reports the minimum SAD and its address.
// Read-only RAM master: synchronous-read data is compared two edges after its address is driven.
module sad_min_reader #(
    parameter int DATA_WIDTH  = 10,
    parameter int ADDR_WIDTH  = 2,
    parameter int NUM_ENTRIES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] min_sad,
    output logic [ADDR_WIDTH-1:0] min_addr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One extra counter bit so a full 2**ADDR_WIDTH scan cannot wrap early.
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_ENTRIES - 1);

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    busy_q;
    logic                    done_q;
    logic [DATA_WIDTH-1:0]   min_sad_q;
    logic [ADDR_WIDTH-1:0]   min_addr_q;
    logic [DATA_WIDTH-1:0]   run_min_q;
    logic [ADDR_WIDTH-1:0]   run_idx_q;
    logic                    seen_q;
    logic                    vld_p1_q;
    logic [ADDR_WIDTH-1:0]   idx_p1_q;

    logic                    vld_p0;
    logic                    upd;
    logic [DATA_WIDTH-1:0]   run_min_d;
    logic [ADDR_WIDTH-1:0]   run_idx_d;

    assign vld_p0 = (state_q == SCAN);

    // First compare always captures, so an all-ones entry is still reported.
    always_comb begin
        upd       = vld_p1_q && (!seen_q || (ram_q < run_min_q));
        run_min_d = run_min_q;
        run_idx_d = run_idx_q;
        if (upd) begin
            run_min_d = ram_q;
            run_idx_d = idx_p1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            min_sad_q  <= '0;
            min_addr_q <= '0;
            run_min_q  <= '0;
            run_idx_q  <= '0;
            seen_q     <= 1'b0;
            vld_p1_q   <= 1'b0;
            idx_p1_q   <= '0;
        end else begin
            done_q    <= 1'b0;
            vld_p1_q  <= vld_p0;
            idx_p1_q  <= cnt_q[ADDR_WIDTH-1:0];
            run_min_q <= run_min_d;
            run_idx_q <= run_idx_d;
            if (upd) begin
                seen_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= SCAN;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        run_min_q <= '1;
                        run_idx_q <= '0;
                        seen_q    <= 1'b0;
                    end
                end
                SCAN: begin
                    if (cnt_q == LAST_CNT) begin
                        state_q <= DRAIN;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DRAIN: begin
                    // The last entry is compared on this same edge; publish the merged result.
                    if (vld_p1_q) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        min_sad_q  <= run_min_d;
                        min_addr_q <= run_idx_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_addr = cnt_q[ADDR_WIDTH-1:0];
    assign ram_we   = 1'b0;
    assign busy     = busy_q;
    assign done     = done_q;
    assign min_sad  = min_sad_q;
    assign min_addr = min_addr_q;

endmodule

// File: tb/tb_sad_min_reader.sv
// Directed bench for sad_min_reader with a synchronous-read RAM model.
module tb_sad_min_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] ram_addr;
    logic       ram_we;
    logic [9:0] ram_q;
    logic       busy;
    logic       done;
    logic [9:0] min_sad;
    logic [1:0] min_addr;
    logic [9:0] mem [4];

    int tests = 0;
    int fails = 0;

    sad_min_reader #(.DATA_WIDTH(10), .ADDR_WIDTH(2), .NUM_ENTRIES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_q    (ram_q),
        .busy     (busy),
        .done     (done),
        .min_sad  (min_sad),
        .min_addr (min_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_q <= mem[ram_addr];

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load(input int a, input int b, input int c, input int d);
        mem[0] = 10'(a); mem[1] = 10'(b); mem[2] = 10'(c); mem[3] = 10'(d);
    endtask

    // i counts edges from the start edge (i = 0); sampling is at the following negedge.
    task automatic scan(input string tag, input int e_min, input int e_addr,
                        input int prev_min, input int restart_at, input bit chk_seq);
        int busy_cnt  = 0;
        int done_cnt  = 0;
        int done_edge = -1;
        @(negedge clk) start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (i == restart_at - 1) start = 1'b1;
            if (i == restart_at) start = 1'b0;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                done_edge = i;
            end
            if (chk_seq && i < 6) chk({tag, "_addr_seq"}, ram_addr, (i < 4) ? i : 3);
            if (i == 4) chk({tag, "_min_hold"}, min_sad, prev_min);
            chk({tag, "_we"}, ram_we, 0);
        end
        chk({tag, "_busy_cycles"}, busy_cnt, 5);
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_done_edge"}, done_edge, 5);
        chk({tag, "_min_sad"}, min_sad, e_min);
        chk({tag, "_min_addr"}, min_addr, e_addr);
    endtask

    initial begin
        int done_cnt;
        int d1;
        int d2;
        rst   = 1'b1;
        start = 1'b0;
        load(0, 0, 0, 0);
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_min_sad", min_sad, 0);
        chk("rst_min_addr", min_addr, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_we", ram_we, 0);
        @(negedge clk) rst = 1'b0;

        load(37, 12, 50, 12);
        scan("tie", 12, 1, 0, -1, 1'b0);

        load(1023, 1023, 1023, 1023);
        scan("ones", 1023, 0, 12, -1, 1'b0);

        load(900, 800, 700, 3);
        scan("desc", 3, 3, 1023, -1, 1'b1);

        load(5, 9, 9, 9);
        scan("restart_ign", 5, 0, 3, 2, 1'b0);

        // Reset three edges into a scan.
        load(40, 30, 20, 10);
        @(negedge clk) start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_min_sad", min_sad, 0);
        chk("abort_min_addr", min_addr, 0);
        chk("abort_ram_addr", ram_addr, 0);
        @(negedge clk) rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 0);
        scan("after_abort", 10, 3, 0, -1, 1'b0);

        // start held high across the done cycle: back-to-back scans.
        load(37, 12, 50, 12);
        done_cnt = 0;
        d1 = -1;
        d2 = -1;
        @(negedge clk) start = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (d1 < 0) d1 = i;
                else d2 = i;
            end
            if (i == 6) chk("held_busy_again", busy, 1);
            if (i == 5 || i == 11) begin
                chk("held_min_sad", min_sad, 12);
                chk("held_min_addr", min_addr, 1);
            end
            chk("held_we", ram_we, 0);
        end
        start = 1'b0;
        chk("held_done_count", done_cnt, 2);
        chk("held_done1_edge", d1, 5);
        chk("held_done2_edge", d2, 11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
